// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side burst drain engine.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_BURST = 2'd1,
        RD_FLUSH = 2'd2
    } rd_state_e;

    localparam logic BEAT_LAST = 1'b1;
    localparam logic BEAT_MID  = 1'b0;

    // Flush beats are always single-beat bursts; burst beats carry last only on the final pop.
    function automatic logic tag_last(input rd_state_e st, input logic final_beat);
        logic tag_s;
        if (st == RD_FLUSH) begin
            tag_s = BEAT_LAST;
        end else begin
            tag_s = final_beat;
        end
        return tag_s;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus downstream valid/ready stream of the burst reader.
interface fifo_burst_reader_if #(
    parameter int DATA_W = 128
) ();

    logic              o_fifo_rden;
    logic [DATA_W-1:0] i_fifo_rddata;
    logic              i_fifo_empty;
    logic              i_fifo_alm_empty;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              i_ready;
    logic              o_busy;

    modport master (
        output o_fifo_rden,
        input  i_fifo_rddata,
        input  i_fifo_empty,
        input  i_fifo_alm_empty,
        output o_valid,
        output o_data,
        output o_last,
        input  i_ready,
        output o_busy
    );

    modport slave (
        input  o_fifo_rden,
        output i_fifo_rddata,
        output i_fifo_empty,
        output i_fifo_alm_empty,
        input  o_valid,
        input  o_data,
        input  o_last,
        output i_ready,
        input  o_busy
    );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry {data, last} buffer decoupling FIFO pops from downstream ready.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t      mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] occ_r;
    logic [1:0] occ_s;
    logic       pop_s;

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        pop_s = 1'b0;
        occ_s = occ_r;
        if (pop && (occ_r != 2'd0)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        case ({push, pop_s})
            2'b10:   occ_s = occ_r + 2'd1;
            2'b01:   occ_s = occ_r - 2'd1;
            default: occ_s = occ_r;
        endcase
    end

    // Storage and pointers; reset discards any buffered beats.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= beat_t'{data: push_data, last: push_last};
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            occ_r <= occ_s;
        end
    end

    // Head outputs, forced to zero when the buffer is empty.
    always_comb begin
        head_valid = (occ_r != 2'd0);
        if (head_valid) begin
            head_data = mem_r[rd_ptr_r].data;
            head_last = mem_r[rd_ptr_r].last;
        end else begin
            head_data = '0;
            head_last = BEAT_MID;
        end
    end

    assign occ = occ_r;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains the FIFO into fixed-length bursts, with a starvation timer that
// flushes stragglers as single-beat bursts.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input logic                clk,
    input logic                rstn,
    fifo_burst_reader_if.master rd
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    rd_state_e         state_r;
    rd_state_e         state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [TMR_W-1:0]  tmr_r;
    logic [TMR_W-1:0]  tmr_s;
    logic              rden_s;
    logic              push_last_s;
    logic [1:0]        occ_s;
    logic              head_valid_s;
    logic [DATA_W-1:0] head_data_s;
    logic              head_last_s;
    logic              accept_s;

    // Pop enable uses only registered state and FIFO flags, never i_ready.
    always_comb begin
        rden_s = 1'b0;
        if (rstn && ((state_r == RD_BURST) || (state_r == RD_FLUSH)) &&
            !rd.i_fifo_empty && (occ_s != 2'd2)) begin
            rden_s = 1'b1;
        end else begin
            rden_s = 1'b0;
        end
    end

    // Next-state, beat counter, starvation timer and last tagging.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        tmr_s       = tmr_r;
        push_last_s = tag_last(state_r, (cnt_r == CNT_LAST));
        case (state_r)
            RD_IDLE: begin
                if (!rd.i_fifo_alm_empty) begin
                    state_s = RD_BURST;
                    cnt_s   = '0;
                    tmr_s   = '0;
                end else if (!rd.i_fifo_empty) begin
                    if (tmr_r == TMR_LAST) begin
                        state_s = RD_FLUSH;
                        cnt_s   = '0;
                        tmr_s   = '0;
                    end else begin
                        tmr_s = tmr_r + TMR_W'(1);
                    end
                end else begin
                    tmr_s = '0;
                end
            end
            RD_BURST: begin
                // An empty FIFO stalls the burst here with no timeout.
                if (rden_s) begin
                    if (cnt_r == CNT_LAST) begin
                        state_s = RD_IDLE;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = RD_BURST;
                end
            end
            RD_FLUSH: begin
                if (rden_s) begin
                    if (cnt_r == CNT_LAST) begin
                        state_s = RD_IDLE;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else if (rd.i_fifo_empty) begin
                    state_s = RD_IDLE;
                end else begin
                    state_s = RD_FLUSH;
                end
            end
            default: begin
                state_s = RD_IDLE;
                cnt_s   = '0;
                tmr_s   = '0;
            end
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= RD_IDLE;
            cnt_r   <= '0;
            tmr_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            tmr_r   <= tmr_s;
        end
    end

    assign accept_s = head_valid_s && rd.i_ready;

    rd_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .rstn       (rstn),
        .push       (rden_s),
        .push_data  (rd.i_fifo_rddata),
        .push_last  (push_last_s),
        .pop        (accept_s),
        .occ        (occ_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s),
        .head_last  (head_last_s)
    );

    assign rd.o_fifo_rden = rden_s;
    assign rd.o_valid     = head_valid_s;
    assign rd.o_data      = head_data_s;
    assign rd.o_last      = head_last_s;
    assign rd.o_busy      = (state_r != RD_IDLE) || (occ_s != 2'd0);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: FIFO model feeds the DUT, a
// scoreboard of {last, data} checks every accepted beat.
module tb_fifo_burst_reader;

    localparam int DW = 128;

    logic clk;
    logic rstn;

    fifo_burst_reader_if #(.DATA_W(DW)) ifc ();

    fifo_burst_reader #(
        .DATA_W    (DW),
        .BURST_LEN (4),
        .TIMEOUT   (16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .rd   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q [$];
    logic [DW:0]   sb_q   [$];
    int tests_run    = 0;
    int tests_failed = 0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // FIFO model outputs; LOW_TH = 2.
    task automatic fifo_update();
        ifc.i_fifo_empty     = (fifo_q.size() == 0);
        ifc.i_fifo_alm_empty = (fifo_q.size() < 2);
        ifc.i_fifo_rddata    = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [DW-1:0] w, input logic last);
        fifo_q.push_back(w);
        sb_q.push_back({last, w});
        fifo_update();
    endtask

    // One clock: sample before the edge, update models and scoreboard after it.
    task automatic tick(output logic rd, output logic vld);
        logic          acc;
        logic [DW-1:0] d;
        logic          l;
        logic [DW:0]   e;
        logic [DW-1:0] dummy;
        #1;
        rd  = ifc.o_fifo_rden;
        vld = ifc.o_valid;
        acc = ifc.o_valid && ifc.i_ready;
        d   = ifc.o_data;
        l   = ifc.o_last;
        @(posedge clk);
        #1;
        if (rd && (fifo_q.size() > 0)) begin
            dummy = fifo_q.pop_front();
        end
        fifo_update();
        if (acc) begin
            chk1("sb_has_entry", (sb_q.size() != 0), 1'b1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("beat_data", d, e[DW-1:0]);
                chk1("beat_last", l, e[DW]);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        logic rd;
        logic vl;
        int   n;
        n = 0;
        while (((sb_q.size() != 0) || ifc.o_valid) && (n < budget)) begin
            tick(rd, vl);
            n++;
        end
        chk1({tag, "_in_budget"}, (n < budget), 1'b1);
        chk1({tag, "_fifo_empty"}, (fifo_q.size() == 0), 1'b1);
    endtask

    logic          rd;
    logic          vl;
    logic [6:0]    rd_exp;
    logic [6:0]    vl_exp;
    logic [DW-1:0] w [8];

    initial begin
        rstn                 = 1'b0;
        ifc.i_ready          = 1'b0;
        ifc.i_fifo_empty     = 1'b1;
        ifc.i_fifo_alm_empty = 1'b1;
        ifc.i_fifo_rddata    = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifc.i_fifo_empty     = 1'($urandom_range(0, 1));
            ifc.i_fifo_alm_empty = 1'($urandom_range(0, 1));
            ifc.i_fifo_rddata    = rnd_word();
            ifc.i_ready          = 1'($urandom_range(0, 1));
            #1;
            chk1("rst_rden_pre", ifc.o_fifo_rden, 1'b0);
            @(posedge clk);
            #1;
            chk1("rst_rden_post", ifc.o_fifo_rden, 1'b0);
            chk1("rst_valid", ifc.o_valid, 1'b0);
            chk1("rst_last", ifc.o_last, 1'b0);
            chk1("rst_busy", ifc.o_busy, 1'b0);
            chk("rst_data", ifc.o_data, '0);
        end
        @(negedge clk);
        rstn        = 1'b1;
        ifc.i_ready = 1'b1;
        fifo_update();
        #1;
        chk1("post_rst_rden", ifc.o_fifo_rden, 1'b0);
        chk1("post_rst_valid", ifc.o_valid, 1'b0);
        chk1("post_rst_busy", ifc.o_busy, 1'b0);

        // Full burst A0..A3
        for (int i = 0; i < 4; i++) begin
            w[i] = rnd_word();
            push_word(w[i], (i == 3));
        end
        rd_exp = 7'b0011110;
        vl_exp = 7'b0111100;
        for (int i = 0; i < 7; i++) begin
            tick(rd, vl);
            chk1($sformatf("burst_rden_c%0d", i), rd, rd_exp[i]);
            chk1($sformatf("burst_valid_c%0d", i), vl, vl_exp[i]);
        end
        chk1("burst_sb_empty", (sb_q.size() == 0), 1'b1);

        // Backpressure with 8 words
        for (int i = 0; i < 8; i++) begin
            w[i] = rnd_word();
            push_word(w[i], ((i == 3) || (i == 7)));
        end
        tick(rd, vl);
        tick(rd, vl);
        tick(rd, vl);
        ifc.i_ready = 1'b0;
        tick(rd, vl);
        #1;
        chk1("bp_rden_drop", ifc.o_fifo_rden, 1'b0);
        chk1("bp_valid", ifc.o_valid, 1'b1);
        chk("bp_hold_data0", ifc.o_data, w[1]);
        tick(rd, vl);
        chk1("bp_rden_still_low", rd, 1'b0);
        chk("bp_hold_data1", ifc.o_data, w[1]);
        ifc.i_ready = 1'b1;
        drain("bp", 40);
        chk1("bp_busy_idle", ifc.o_busy, 1'b0);

        // Timeout flush of a single straggler
        w[0] = rnd_word();
        push_word(w[0], 1'b1);
        for (int i = 0; i < 17; i++) begin
            tick(rd, vl);
            chk1($sformatf("to_rden_c%0d", i), rd, (i == 16));
        end
        #1;
        chk1("to_valid", ifc.o_valid, 1'b1);
        chk1("to_last", ifc.o_last, 1'b1);
        chk1("to_busy_during", ifc.o_busy, 1'b1);
        tick(rd, vl);
        #1;
        chk1("to_busy_after", ifc.o_busy, 1'b0);
        chk1("to_valid_after", ifc.o_valid, 1'b0);

        // Stalled burst: C0,C1 then 20+ starved cycles, then C2,C3
        for (int i = 0; i < 2; i++) begin
            w[i] = rnd_word();
            push_word(w[i], 1'b0);
        end
        for (int i = 0; i < 24; i++) begin
            tick(rd, vl);
        end
        chk1("stall_busy", ifc.o_busy, 1'b1);
        chk1("stall_valid", ifc.o_valid, 1'b0);
        chk1("stall_sb_empty", (sb_q.size() == 0), 1'b1);
        for (int i = 2; i < 4; i++) begin
            w[i] = rnd_word();
            push_word(w[i], (i == 3));
        end
        drain("stall", 20);
        chk1("stall_busy_end", ifc.o_busy, 1'b0);

        // Reset in the middle of a burst
        for (int i = 0; i < 4; i++) begin
            w[i] = rnd_word();
            push_word(w[i], (i == 3));
        end
        tick(rd, vl);
        tick(rd, vl);
        tick(rd, vl);
        rstn = 1'b0;
        #1;
        chk1("mid_rst_fifo_nonempty", (fifo_q.size() == 2), 1'b1);
        chk1("mid_rst_no_pop", ifc.o_fifo_rden, 1'b0);
        @(posedge clk);
        #1;
        chk1("mid_rst_valid", ifc.o_valid, 1'b0);
        chk1("mid_rst_busy", ifc.o_busy, 1'b0);
        chk1("mid_rst_last", ifc.o_last, 1'b0);
        fifo_q.delete();
        sb_q.delete();
        fifo_update();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk1("mid_rst_after_rden", ifc.o_fifo_rden, 1'b0);
        chk1("mid_rst_after_valid", ifc.o_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w[i] = rnd_word();
            push_word(w[i], (i == 3));
        end
        drain("restart", 20);
        chk1("restart_busy_end", ifc.o_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side drain engine for the synchronous FIFO. Pops words from the FIFO's fall-through read port and presents them on a valid/ready stream grouped into fixed-length bursts with `o_last` on the final beat. A starvation timer flushes stragglers when the FIFO holds data but never reaches the burst threshold. It sits between the FIFO and the downstream consumer, and a 2-entry output buffer gives full throughput without a combinational `i_ready`→`o_fifo_rden` path.

## Interface
- `DATA_W`, default 128: word width; must match the FIFO.
- `BURST_LEN`, default 4: beats per burst; must be ≥1.
- `TIMEOUT`, default 16: IDLE cycles with non-empty, almost-empty FIFO before a flush starts; must be ≥1.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset; synchronous, active-low.
- `o_fifo_rden`  out  1: FIFO read enable. The FIFO pops on this edge when not empty.
- `i_fifo_rddata`  in  `DATA_W`: FIFO head word; combinational, valid while `i_fifo_empty`=0.
- `i_fifo_empty`  in  1: FIFO empty.
- `i_fifo_alm_empty`  in  1: FIFO almost-empty (count < FIFO LOW_TH).
- `o_valid`  out  1: stream beat valid.
- `o_data`  out  `DATA_W`: stream beat data.
- `o_last`  out  1: final beat of a burst.
- `i_ready`  in  1: consumer accepts the beat when `o_valid` and `i_ready` are both high.
- `o_busy`  out  1: state≠IDLE or buffer occupied.

## Operation
- **States.** IDLE, BURST, FLUSH; the state enum comes from the package.
- **Buffer.** A 2-entry FIFO of {data, last} with occupancy `occ` (0..2). Output head: `o_valid`=(occ≠0), `o_data`/`o_last` from the head entry.
- **Pop condition.** `o_fifo_rden` = rstn ∧ (state∈{BURST,FLUSH}) ∧ ¬`i_fifo_empty` ∧ (occ<2).
  - It depends only on registered state and inputs from the FIFO, never on `i_ready`.
  - On a pop, `i_fifo_rddata` is captured into the buffer at the same edge.
- **Beat counter.**
  - Width $clog2(BURST_LEN+1).
  - Cleared on entry to BURST or FLUSH; increments per pop.
- **IDLE.**
  - `i_fifo_alm_empty`=0 → BURST. This has priority over the timer.
  - Else if ¬`i_fifo_empty`: the timer increments. Timer width is $clog2(TIMEOUT+1). When the timer = TIMEOUT−1 → FLUSH.
  - Timer clears when `i_fifo_empty`=1 or on leaving IDLE.
- **BURST.**
  - Pops until BURST_LEN beats; the BURST_LEN-th pop is tagged last=1, then → IDLE.
  - If the FIFO runs empty mid-burst, the burst stalls indefinitely. It has no timeout and never ends early.
- **FLUSH.**
  - Each popped beat is a single-beat burst with last=1.
  - → IDLE when `i_fifo_empty`=1 at a cycle with no pop, or after BURST_LEN pops.
- **Simultaneous push/pop on the buffer.** occ is unchanged; the head advances and the new entry is written behind it.
- **Beat integrity.** No beat is dropped, duplicated or reordered.

## Timing
- Pop at edge N: the beat is visible on `o_valid`/`o_data` in the cycle after edge N (1-cycle latency). If a beat is already queued ahead of it, the new beat waits behind that beat.
- Steady state with `i_ready`=1: one beat per cycle, occ stays at 1.
- IDLE→BURST: the first pop happens in the cycle after `i_fifo_alm_empty` is sampled low.
- **Reset values** while `rstn`=0 and in the cycle after:
  - State IDLE; occ, beat counter and timer 0.
  - `o_fifo_rden`=0 combinationally throughout.
  - `o_valid`=0, `o_last`=0, `o_data`=0, `o_busy`=0.
  - Buffered beats are discarded.
- **Reset mid-burst.** No pop occurs in the reset cycle; the stream restarts cleanly with no partial last.

## Structure
- Package `fifo_rd_pkg`:
  - `rd_state_e` {RD_IDLE, RD_BURST, RD_FLUSH}.
  - Parameterised beat struct {data, last}. Width is passed via parameter; the package holds the last-flag constant and helpers.
- Sub-module `rd_skid_buf`: the 2-entry buffer with push/pop/occ and head outputs.
- Top: FSM, counters, rden logic.

## Test plan
Test configuration: DATA_W=128, BURST_LEN=4, TIMEOUT=16, FIFO LOW_TH=2.

1. **Reset.** Hold `rstn`=0 for 3 cycles with random inputs → `o_fifo_rden`=0 every cycle; `o_valid`=`o_last`=`o_busy`=0.
2. **Full burst.** Write A0..A3 with `i_ready`=1 → `o_fifo_rden` high for 4 consecutive cycles; `o_valid` high 4 cycles starting 1 cycle later; data A0..A3 in order; `o_last`=1 on A3 only.
3. **Backpressure.** Load 8 words; `i_ready`=0 after the first beat → occ reaches 2, `rden` drops, `o_data` holds. Release `i_ready` → remaining beats arrive in order with last on beats 4 and 8; no loss or duplication.
4. **Timeout flush.** Write a single word B0 → after 16 IDLE cycles the block enters FLUSH, pops B0, emits it with `o_last`=1, and returns to IDLE; `o_busy` low once the beat is accepted.
5. **Stalled burst.** Write C0,C1; starve for 20 cycles; then write C2,C3 → C0,C1 emitted with last=0, no flush during the starve, C3 carries last=1.
6. **Reset mid-burst.** Assert `rstn`=0 after 2 beats of a 4-beat burst → no pop in the reset cycle; `o_valid`=0 afterwards. A subsequent burst of D0..D3 carries last on D3 only.
